// File: rtl/seg7_pkg.sv
// Shared constants for active-low 7-segment glyphs and the scan reader FSM.
package seg7_pkg;

    // Segment bit positions within seg_n, format {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A_HEX = 7'b0001000;
    localparam logic [6:0] SEG_B_HEX = 7'b0000011;
    localparam logic [6:0] SEG_C_HEX = 7'b1000110;
    localparam logic [6:0] SEG_D_HEX = 7'b0100001;
    localparam logic [6:0] SEG_E_HEX = 7'b0000110;
    localparam logic [6:0] SEG_F_HEX = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        COLLECT,
        FRAME,
        PRESENT
    } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder from an active-low 7-segment glyph back to its hex value.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] val,
    output logic       err
);

    always_comb begin
        val = 4'h0;
        err = 1'b0;
        case (seg_n)
            SEG_0:     val = 4'h0;
            SEG_1:     val = 4'h1;
            SEG_2:     val = 4'h2;
            SEG_3:     val = 4'h3;
            SEG_4:     val = 4'h4;
            SEG_5:     val = 4'h5;
            SEG_6:     val = 4'h6;
            SEG_7:     val = 4'h7;
            SEG_8:     val = 4'h8;
            SEG_9:     val = 4'h9;
            SEG_A_HEX: val = 4'hA;
            SEG_B_HEX: val = 4'hB;
            SEG_C_HEX: val = 4'hC;
            SEG_D_HEX: val = 4'hD;
            SEG_E_HEX: val = 4'hE;
            SEG_F_HEX: val = 4'hF;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reconstructs digit values from a multiplexed 7-segment bus and presents
// frame-stable snapshots on a valid/ready interface.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SETTLE        = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [N_DIGITS-1:0]   an_n,
    output logic [4*N_DIGITS-1:0] out_data,
    output logic [N_DIGITS-1:0]   out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovr
);

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_FIRE = 8'(SETTLE - 2);
    localparam logic [3:0] MATCH_MAX   = 4'(STABLE_FRAMES);

    logic [6:0]            r_segMeta, r_segSync, r_segPrev;
    logic [N_DIGITS-1:0]   r_anMeta, r_anSync, r_anPrev;
    logic [7:0]            r_settleCnt;
    logic [4*N_DIGITS-1:0] r_digits, r_prevDigits, r_outData;
    logic [N_DIGITS-1:0]   r_errs, r_prevErrs, r_outErr, r_seen;
    logic [3:0]            r_matchCnt;
    logic                  r_outValid, r_ovr, r_havePresented;
    state_t                r_state, w_stateNext;

    logic [3:0]            w_val;
    logic                  w_decErr;
    logic                  w_same, w_oneHot, w_capture;
    logic                  w_frameEqual, w_sameAsShown, w_qualify;
    logic [3:0]            w_matchNext;
    logic                  w_isFrame, w_isPresent, w_drop;

    seg7_to_hex u_dec (
        .seg_n (r_segSync),
        .val   (w_val),
        .err   (w_decErr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segMeta <= '0;
            r_segSync <= '0;
            r_segPrev <= '0;
            r_anMeta  <= '0;
            r_anSync  <= '0;
            r_anPrev  <= '0;
        end else begin
            r_segMeta <= seg_n;
            r_segSync <= r_segMeta;
            r_segPrev <= r_segSync;
            r_anMeta  <= an_n;
            r_anSync  <= r_anMeta;
            r_anPrev  <= r_anSync;
        end
    end

    // Capture on the SETTLE-th identical sample; saturation keeps it to one per dwell.
    assign w_same    = ({r_segSync, r_anSync} == {r_segPrev, r_anPrev});
    assign w_oneHot  = ($countones(~r_anSync) == 1);
    assign w_capture = w_same && (r_settleCnt == SETTLE_FIRE) && w_oneHot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settleCnt <= '0;
        end else if (!w_same) begin
            r_settleCnt <= '0;
        end else if (r_settleCnt < SETTLE_MAX) begin
            r_settleCnt <= r_settleCnt + 8'd1;
        end
    end

    assign w_frameEqual  = ({r_digits, r_errs} == {r_prevDigits, r_prevErrs});
    assign w_matchNext   = !w_frameEqual ? 4'd1 :
                           (r_matchCnt >= MATCH_MAX) ? MATCH_MAX : r_matchCnt + 4'd1;
    assign w_sameAsShown = r_havePresented && ({r_digits, r_errs} == {r_outData, r_outErr});
    assign w_qualify     = (r_state == FRAME) && (w_matchNext == MATCH_MAX) && !w_sameAsShown;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            COLLECT: if (&r_seen) w_stateNext = FRAME;
            FRAME:   w_stateNext = (w_qualify && !r_outValid) ? PRESENT : COLLECT;
            PRESENT: w_stateNext = COLLECT;
            default: w_stateNext = COLLECT;
        endcase
    end

    always_comb begin
        w_isFrame   = (r_state == FRAME);
        w_isPresent = (r_state == PRESENT);
        w_drop      = w_qualify && r_outValid;
    end

    // Captures run in every state, so a digit settling during FRAME seeds the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_errs   <= '0;
            r_seen   <= '0;
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (w_capture && !r_anSync[i]) begin
                    r_digits[4*i +: 4] <= w_val;
                    r_errs[i]          <= w_decErr;
                end
            end
            if (w_isFrame) begin
                r_seen <= w_capture ? ~r_anSync : '0;
            end else if (w_capture) begin
                r_seen <= r_seen | ~r_anSync;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prevDigits <= '0;
            r_prevErrs   <= '0;
            r_matchCnt   <= '0;
        end else if (w_isFrame) begin
            r_prevDigits <= r_digits;
            r_prevErrs   <= r_errs;
            r_matchCnt   <= w_matchNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData       <= '0;
            r_outErr        <= '0;
            r_outValid      <= 1'b0;
            r_havePresented <= 1'b0;
            r_ovr           <= 1'b0;
        end else begin
            r_ovr <= w_drop;
            if (w_isPresent) begin
                r_outData       <= r_prevDigits;
                r_outErr        <= r_prevErrs;
                r_outValid      <= 1'b1;
                r_havePresented <= 1'b1;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_data  = r_outData;
    assign out_err   = r_outErr;
    assign out_valid = r_outValid;
    assign ovr       = r_ovr;

endmodule
